hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use bubbles, redirect flushes, memory freeze.
// Produces stall/flush/bubble controls combinationally and keeps stall/redirect performance counters.
module hazard_ctrl #(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic             valid_ID,
  input  logic [4:0]       rd_EX,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic             B_JUMP,
  input  logic             dmem_busy,
  input  logic             clr_cnt,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             flush_ID,
  output logic             stall_EX,
  output logic             bubble_EX,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] LU_RELOAD = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYC);

  state_t     cur, nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       lu;
  logic       flush_evt;

  assign state = cur;

  assign lu = valid_ID & MemRead_EX & RegWrite_EX & (rd_EX != 5'd0) &
              ((rs1_used_ID & (rs1_ID == rd_EX)) | (rs2_used_ID & (rs2_ID == rd_EX)));

  always_comb begin
    nxt       = cur;
    cnt_nxt   = cnt;
    flush_evt = 1'b0;
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    flush_ID  = 1'b0;
    stall_EX  = 1'b0;
    bubble_EX = 1'b0;
    if (dmem_busy) begin
      stall_IF = 1'b1;
      stall_ID = 1'b1;
      stall_EX = 1'b1;
    end else if (B_JUMP) begin
      flush_ID  = 1'b1;
      bubble_EX = 1'b1;
      flush_evt = 1'b1;
      if (FLUSH_CYC > 0) begin
        nxt     = FLUSH;
        cnt_nxt = FL_RELOAD;
      end else begin
        nxt     = RUN;
        cnt_nxt = 2'd0;
      end
    end else begin
      case (cur)
        RUN: begin
          if (lu) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_EX = 1'b1;
            if (LOAD_LAT > 1) begin
              nxt     = LU_STALL;
              cnt_nxt = LU_RELOAD;
            end
          end
        end
        LU_STALL: begin
          stall_IF  = 1'b1;
          stall_ID  = 1'b1;
          bubble_EX = 1'b1;
          // The state is left once the count would land on zero, so a reload of N gives N extra cycles.
          cnt_nxt   = cnt - 2'd1;
          if (cnt <= 2'd1) begin
            nxt     = RUN;
            cnt_nxt = 2'd0;
          end
        end
        FLUSH: begin
          flush_ID  = 1'b1;
          bubble_EX = 1'b1;
          cnt_nxt   = cnt - 2'd1;
          if (cnt <= 2'd1) begin
            nxt     = RUN;
            cnt_nxt = 2'd0;
          end
        end
        default: begin
          nxt     = RUN;
          cnt_nxt = 2'd0;
        end
      endcase
    end
    if (rst) begin
      flush_evt = 1'b0;
      stall_IF  = 1'b0;
      stall_ID  = 1'b0;
      flush_ID  = 1'b0;
      stall_EX  = 1'b0;
      bubble_EX = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= RUN;
      cnt <= 2'd0;
    end else if (!dmem_busy) begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_IF && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
